ip_bus_initiator: RTL and testbench
===================================

Name: ip_bus_initiator

Overview:
- Bus master for the internal MSX-50BUS; the initiator side of the protocol that peripheral responders (PPI, PSG, mapper, etc.) implement.
- Accepts single-beat read/write requests from a host-side command port (CPU core or debug bridge) via a valid/ready handshake.
- Drives one-cycle bus strobes and, for reads, waits for bus_read_ready with a timeout.
- Returns one response per request on a pulse-style response port.

Parameters:
- TIMEOUT, 16, cycles after the read strobe to wait for bus_read_ready before aborting (range 2..255).
- OPEN_BUS_DATA, 8'hFF, read data returned on timeout or on an unclaimed space.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_write  in  1  1=write, 0=read.
- req_io  in  1  1=I/O space, 0=memory space.
- req_address  in  16  target address.
- req_wdata  in  8  write data.
- rsp_valid  out  1  one-cycle response pulse; no backpressure.
- rsp_rdata  out  8  read data; 8'h00 for writes.
- rsp_timeout  out  1  qualifies rsp_valid; read aborted by timeout.
- bus_address  out  16  registered address, held until the next accepted request.
- bus_write_data  out  8  registered write data, held until the next accepted request.
- bus_read  out  1  read strobe.
- bus_write  out  1  write strobe.
- bus_io  out  1  I/O space qualifier.
- bus_memory  out  1  memory space qualifier.
- bus_io_cs  in  1  OR of responder I/O claims.
- bus_memory_cs  in  1  OR of responder memory claims.
- bus_read_ready  in  1  OR of responder read-ready.
- bus_read_data  in  8  OR of responder read data; valid only while bus_read_ready=1.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, wait counter=0.
  - Outputs during reset: all bus_* outputs 0; rsp_valid=0, rsp_rdata=00h, rsp_timeout=0; req_ready=0.
  - req_ready=1 from the first cycle after reset deasserts.
- FSM states: IDLE, STROBE, WAIT, RESP.
  - req_ready=1 only in IDLE.
- IDLE:
  - On accept (cycle T): capture address, wdata, write, io into the bus_address and bus_write_data registers; go to STROBE.
  - Claim check: sel_cs = req_io ? bus_io_cs : bus_memory_cs, sampled at T.
  - Read with sel_cs=0: no bus cycle. Go directly to RESP with rdata=OPEN_BUS_DATA, timeout=0.
- STROBE (T+1), exactly one cycle:
  - bus_write=write, bus_read=!write, bus_io=io, bus_memory=!io. All four strobes are 0 in every other state.
  - Write: go to RESP with rdata=00h.
  - Read: clear counter, go to WAIT.
- WAIT:
  - Each cycle, if bus_read_ready=1: capture bus_read_data, go to RESP, timeout=0.
  - Otherwise increment the counter. When it reaches TIMEOUT-1: rdata=OPEN_BUS_DATA, timeout=1, go to RESP.
  - If ready and the final count coincide, ready wins.
  - Earliest ready is T+2 (single-register responder), giving rsp_valid at T+3.
- RESP:
  - rsp_valid=1 for one cycle with rsp_rdata/rsp_timeout; go to IDLE.
  - rsp_rdata and rsp_timeout hold their values until the next RESP.
- Latency (accept to rsp_valid):
  - write: 2 cycles.
  - unclaimed read: 1 cycle.
  - claimed read: 3 + extra wait cycles.
- Back-to-back: a new accept is possible the cycle after RESP.
  - Minimum spacing between accepts: write 3 cycles, read 4 cycles.
- bus_read_ready outside WAIT (late, or after timeout): ignored, no response generated.
- Reset mid-operation: the transaction is dropped, no rsp_valid, strobes deassert the following cycle.
- Counter width: 8 bits.

Test Plan:
- Write: req {write=1, io=1, addr=00A8h, wdata=5Ah} at T.
  - Required: bus_write=1, bus_io=1, bus_address=00A8h, bus_write_data=5Ah for exactly cycle T+1.
  - Required: rsp_valid at T+2 with rdata=00h, timeout=0.
- Read with single-register responder: read io=1, 00A9h; responder asserts ready with data 3Ch at T+2.
  - Required: bus_read pulse at T+1 only; rsp_valid at T+3, rdata=3Ch, timeout=0.
- Timeout: read with bus_io_cs=1 and no ready, TIMEOUT=16.
  - Required: rsp_valid with rdata=FFh, timeout=1, 18 cycles after accept.
  - Required: a ready arriving 2 cycles later produces no response.
- Unclaimed space: memory read with bus_memory_cs=0.
  - Required: no bus strobe; rsp_valid at T+1, rdata=FFh, timeout=0.
- Back-to-back traffic: hold req_valid for a write then a read.
  - Required: req_ready low between accept and RESP; second accept exactly one cycle after the first rsp_valid.
- Reset mid-operation: assert reset during WAIT.
  - Required: no rsp_valid; all outputs at reset values; req_ready=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/ip_bus_initiator.sv
// ip_bus_initiator: MSX-50BUS master turning host read/write requests into one-cycle bus strobes
// Ports:
//   clk, reset             - system clock, synchronous active-high reset
//   req_*                  - host command port (valid/ready), single-beat read/write
//   rsp_*                  - one-cycle response pulse with read data and timeout flag
//   bus_address/write_data - registered, held until the next accepted request
//   bus_read/write/io/mem  - strobes, high only in the STROBE cycle
//   bus_*_cs, bus_read_*   - OR-ed responder claims, read-ready and read data
module ip_bus_initiator #(
  parameter int TIMEOUT = 16,
  parameter logic [7:0] OPEN_BUS_DATA = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_io,
  input  logic [15:0] req_address,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_timeout,
  output logic [15:0] bus_address,
  output logic [7:0]  bus_write_data,
  output logic        bus_read,
  output logic        bus_write,
  output logic        bus_io,
  output logic        bus_memory,
  input  logic        bus_io_cs,
  input  logic        bus_memory_cs,
  input  logic        bus_read_ready,
  input  logic [7:0]  bus_read_data
);
  typedef enum logic [1:0] {IDLE, STROBE, WAIT, RESP} state_t;
  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        r_write;
  logic        r_req_ready;
  logic        r_rsp_valid;
  logic [7:0]  r_rsp_rdata;
  logic        r_rsp_timeout;
  logic [15:0] r_bus_address;
  logic [7:0]  r_bus_write_data;
  logic        r_bus_read;
  logic        r_bus_write;
  logic        r_bus_io;
  logic        r_bus_memory;
  logic        w_accept;
  logic        w_sel_cs;
  assign w_accept = req_valid & r_req_ready;
  assign w_sel_cs = req_io ? bus_io_cs : bus_memory_cs;
  assign req_ready      = r_req_ready;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_rdata      = r_rsp_rdata;
  assign rsp_timeout    = r_rsp_timeout;
  assign bus_address    = r_bus_address;
  assign bus_write_data = r_bus_write_data;
  assign bus_read       = r_bus_read;
  assign bus_write      = r_bus_write;
  assign bus_io         = r_bus_io;
  assign bus_memory     = r_bus_memory;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= IDLE;
      r_cnt            <= 8'd0;
      r_write          <= 1'b0;
      r_req_ready      <= 1'b0;
      r_rsp_valid      <= 1'b0;
      r_rsp_rdata      <= 8'h00;
      r_rsp_timeout    <= 1'b0;
      r_bus_address    <= 16'h0000;
      r_bus_write_data <= 8'h00;
      r_bus_read       <= 1'b0;
      r_bus_write      <= 1'b0;
      r_bus_io         <= 1'b0;
      r_bus_memory     <= 1'b0;
    end else begin
      r_rsp_valid  <= 1'b0;
      r_bus_read   <= 1'b0;
      r_bus_write  <= 1'b0;
      r_bus_io     <= 1'b0;
      r_bus_memory <= 1'b0;
      case (r_state)
        IDLE: begin
          r_req_ready <= 1'b1;
          if (w_accept) begin
            r_req_ready      <= 1'b0;
            r_write          <= req_write;
            r_bus_address    <= req_address;
            r_bus_write_data <= req_wdata;
            // An unclaimed read never touches the bus and answers open-bus data at once
            if (!req_write && !w_sel_cs) begin
              r_state       <= RESP;
              r_rsp_valid   <= 1'b1;
              r_rsp_rdata   <= OPEN_BUS_DATA;
              r_rsp_timeout <= 1'b0;
            end else begin
              r_state      <= STROBE;
              r_bus_write  <= req_write;
              r_bus_read   <= !req_write;
              r_bus_io     <= req_io;
              r_bus_memory <= !req_io;
            end
          end
        end
        STROBE: begin
          if (r_write) begin
            r_state       <= RESP;
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= 8'h00;
            r_rsp_timeout <= 1'b0;
          end else begin
            r_state <= WAIT;
            r_cnt   <= 8'd0;
          end
        end
        WAIT: begin
          // Ready is tested first so it wins over a coinciding final count
          if (bus_read_ready) begin
            r_state       <= RESP;
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= bus_read_data;
            r_rsp_timeout <= 1'b0;
          end else if (r_cnt == 8'(TIMEOUT - 1)) begin
            r_state       <= RESP;
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= OPEN_BUS_DATA;
            r_rsp_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        RESP: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ip_bus_initiator.sv
// tb_ip_bus_initiator: directed checks of the MSX-50BUS initiator
module tb_ip_bus_initiator;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic        req_io = 1'b0;
  logic [15:0] req_address = 16'h0000;
  logic [7:0]  req_wdata = 8'h00;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_timeout;
  logic [15:0] bus_address;
  logic [7:0]  bus_write_data;
  logic        bus_read;
  logic        bus_write;
  logic        bus_io;
  logic        bus_memory;
  logic        bus_io_cs = 1'b0;
  logic        bus_memory_cs = 1'b0;
  logic        bus_read_ready = 1'b0;
  logic [7:0]  bus_read_data = 8'h00;
  int tests = 0;
  int errs = 0;
  int n;
  ip_bus_initiator dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_io(req_io),
    .req_address(req_address), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .bus_address(bus_address), .bus_write_data(bus_write_data),
    .bus_read(bus_read), .bus_write(bus_write), .bus_io(bus_io), .bus_memory(bus_memory),
    .bus_io_cs(bus_io_cs), .bus_memory_cs(bus_memory_cs),
    .bus_read_ready(bus_read_ready), .bus_read_data(bus_read_data)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic req(input logic w, input logic io, input logic [15:0] a, input logic [7:0] d);
    req_valid = 1'b1; req_write = w; req_io = io; req_address = a; req_wdata = d;
  endtask
  task automatic strobes(input string tag, input logic [3:0] exp);
    check(tag, {bus_read, bus_write, bus_io, bus_memory}, exp);
  endtask
  initial begin
    tick(); tick();
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp", {rsp_valid, rsp_timeout, rsp_rdata}, 0);
    strobes("rst_strobes", 4'b0000);
    check("rst_addr", {bus_address, bus_write_data}, 0);
    reset = 1'b0;
    check("rel_req_ready0", req_ready, 0);
    tick();
    check("rel_req_ready1", req_ready, 1);
    // Write
    bus_io_cs = 1'b1;
    bus_memory_cs = 1'b1;
    req(1, 1, 16'h00A8, 8'h5A);
    tick();
    req_valid = 1'b0;
    strobes("wr_strobe", 4'b0110);
    check("wr_addr", bus_address, 16'h00A8);
    check("wr_data", bus_write_data, 8'h5A);
    check("wr_busy", {req_ready, rsp_valid}, 2'b00);
    tick();
    strobes("wr_strobe_off", 4'b0000);
    check("wr_rsp", {rsp_valid, rsp_timeout, rsp_rdata}, {2'b10, 8'h00});
    check("wr_addr_hold", {bus_address, bus_write_data}, {16'h00A8, 8'h5A});
    tick();
    check("wr_rsp_end", {rsp_valid, req_ready}, 2'b01);
    // Read, single-register responder
    req(0, 1, 16'h00A9, 8'h00);
    tick();
    req_valid = 1'b0;
    strobes("rd_strobe", 4'b1010);
    check("rd_addr", bus_address, 16'h00A9);
    tick();
    strobes("rd_strobe_off", 4'b0000);
    bus_read_ready = 1'b1; bus_read_data = 8'h3C;
    tick();
    bus_read_ready = 1'b0; bus_read_data = 8'h00;
    check("rd_rsp", {rsp_valid, rsp_timeout, rsp_rdata}, {2'b10, 8'h3C});
    tick();
    check("rd_rsp_end", rsp_valid, 0);
    check("rd_rdata_hold", rsp_rdata, 8'h3C);
    // Timeout
    req(0, 1, 16'h0099, 8'h00);
    n = 0;
    tick(); n++;
    req_valid = 1'b0;
    while (!rsp_valid && n < 40) begin tick(); n++; end
    check("to_latency", n, 18);
    check("to_rsp", {rsp_valid, rsp_timeout, rsp_rdata}, {2'b11, 8'hFF});
    tick(); tick();
    bus_read_ready = 1'b1; bus_read_data = 8'h55;
    tick();
    bus_read_ready = 1'b0; bus_read_data = 8'h00;
    n = 0;
    for (int i = 0; i < 4; i++) begin n += int'(rsp_valid); tick(); end
    check("to_late_ready", n, 0);
    check("to_rdata_hold", {rsp_timeout, rsp_rdata}, {1'b1, 8'hFF});
    // Ready coinciding with the final count wins
    req(0, 1, 16'h0098, 8'h00);
    tick();
    req_valid = 1'b0;
    for (int i = 1; i < 17; i++) tick();
    bus_read_ready = 1'b1; bus_read_data = 8'hC3;
    tick();
    bus_read_ready = 1'b0; bus_read_data = 8'h00;
    check("race_rsp", {rsp_valid, rsp_timeout, rsp_rdata}, {2'b10, 8'hC3});
    tick();
    // Unclaimed memory read
    bus_memory_cs = 1'b0;
    req(0, 0, 16'h1234, 8'h00);
    tick();
    req_valid = 1'b0;
    strobes("uc_no_strobe", 4'b0000);
    check("uc_rsp", {rsp_valid, rsp_timeout, rsp_rdata}, {2'b10, 8'hFF});
    check("uc_addr", bus_address, 16'h1234);
    tick();
    check("uc_ready_back", {rsp_valid, req_ready}, 2'b01);
    strobes("uc_no_strobe2", 4'b0000);
    // Back-to-back: write then read with req_valid held
    bus_memory_cs = 1'b1;
    req(1, 0, 16'h4000, 8'h11);
    tick();
    req(0, 0, 16'h4001, 8'h00);
    strobes("b2b_wr_strobe", 4'b0101);
    check("b2b_busy1", req_ready, 0);
    tick();
    check("b2b_wr_rsp", {rsp_valid, req_ready}, 2'b10);
    tick();
    check("b2b_ready_again", {rsp_valid, req_ready}, 2'b01);
    tick();
    req_valid = 1'b0;
    strobes("b2b_rd_strobe", 4'b1001);
    check("b2b_rd_addr", bus_address, 16'h4001);
    tick(); tick();
    check("b2b_wait_no_rsp", rsp_valid, 0);
    bus_read_ready = 1'b1; bus_read_data = 8'hA5;
    tick();
    bus_read_ready = 1'b0; bus_read_data = 8'h00;
    check("b2b_rd_rsp", {rsp_valid, rsp_timeout, rsp_rdata}, {2'b10, 8'hA5});
    tick();
    // Reset during WAIT
    req(0, 1, 16'h00AA, 8'h00);
    tick();
    req_valid = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    check("mr_rsp", {rsp_valid, rsp_timeout, rsp_rdata}, 0);
    strobes("mr_strobes", 4'b0000);
    check("mr_bus", {bus_address, bus_write_data}, 0);
    check("mr_req_ready", req_ready, 0);
    reset = 1'b0;
    tick();
    check("mr_ready_after", req_ready, 1);
    n = 0;
    for (int i = 0; i < 20; i++) begin n += int'(rsp_valid); tick(); end
    check("mr_no_rsp", n, 0);
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule
